ysyx_25040111_mul_seq: RTL and testbench

//  Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, issued from EXU beside the ALU.

---
 rtl/ysyx_25040111_mul_pkg.sv | 21 ++
 rtl/ysyx_25040111_cla_add.sv | 60 ++++++
 rtl/ysyx_25040111_mul_seq.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_25040111_mul_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_mul_pkg.sv
// Shared encodings and default widths for the iterative RV32M multiplier.
package ysyx_25040111_mul_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/ysyx_25040111_cla_add.sv
// Carry-lookahead adder: 4-bit lookahead carry groups chained group to group.
// ysyx_25040111_carry computes the four carries of one group from p/g/cin.

module ysyx_25040111_carry (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] co
);

  // Fully expanded lookahead equations; co[i] is the carry out of bit i.
  always_comb begin
    co[0] = g[0] | (p[0] & cin);
    co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (&p & cin);
  end

endmodule

module ysyx_25040111_cla_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0] p;
  logic [W-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  // Each group keeps its own carry signals so the chain is a plain wire path.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic       ci;
    logic [3:0] co_l;
    if (gi == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_grp[gi-1].co_l[3];
    end
    ysyx_25040111_carry u_carry (
      .p   (p[4*gi +: 4]),
      .g   (g[4*gi +: 4]),
      .cin (ci),
      .co  (co_l)
    );
    assign sum[4*gi +: 4] = p[4*gi +: 4] ^ {co_l[2:0], ci};
  end

  assign cout = g_grp[NG-1].co_l[3];

endmodule

// File: rtl/ysyx_25040111_mul_seq.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on accept, multiplied unsigned one bit
// per cycle through the CLA adder, then the sign is re-applied in FIX.
// Optional feature: define YSYX_25040111_MUL_EARLY_OUT_EN to leave BUSY as soon
// as the remaining multiplier bits are zero (a barrel shift in FIX finishes the
// alignment). Default build runs a fixed XLEN+2 cycle latency.
module ysyx_25040111_mul_seq
  import ysyx_25040111_mul_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  mul_state_e        state_q, state_d;
  mul_op_e           op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  // Operand sign handling at accept time
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = ((in_op == MUL_OP_MULH) || (in_op == MUL_OP_MULHSU)) && in_a[XLEN-1];
    b_sgn = (in_op == MUL_OP_MULH) && in_b[XLEN-1];
    a_mag = a_sgn ? (~in_a + XLEN'(1)) : in_a;
    b_mag = b_sgn ? (~in_b + XLEN'(1)) : in_b;
  end

  // Iteration adder: hi + (mplier[0] ? mcand : 0)
  logic [XLEN-1:0] add_b, it_sum;
  logic            it_cout;

  assign add_b = mplier_q[0] ? mcand_q : '0;

  ysyx_25040111_cla_add #(.W(XLEN)) u_iter_add (
    .a    (hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (it_sum),
    .cout (it_cout)
  );

  // Final alignment and sign fix of the 2*XLEN product
  logic [2*XLEN-1:0] prod_fix, neg_sum, fix_prod;
  logic              neg_cout;

`ifdef YSYX_25040111_MUL_EARLY_OUT_EN
  logic [CNT_W-1:0] sh_amt;
  assign sh_amt   = CNT_W'(XLEN) - cnt_q;
  assign prod_fix = {hi_q, lo_q} >> sh_amt;
`else
  assign prod_fix = {hi_q, lo_q};
`endif

  ysyx_25040111_cla_add #(.W(2*XLEN)) u_neg_add (
    .a    (~prod_fix),
    .b    ('0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_cout)
  );

  // A carry out of ~p+1 only happens for p==0, so it doubles as the zero mask.
  assign fix_prod = (neg_q && !neg_cout) ? neg_sum : prod_fix;

  // Next-state and datapath updates; flush overrides everything incl. accept
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d       = mul_op_e'(in_op);
          neg_d      = a_sgn ^ b_sgn;
          mcand_d    = a_mag;
          mplier_d   = b_mag;
          hi_d       = '0;
          lo_d       = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
`ifdef YSYX_25040111_MUL_EARLY_OUT_EN
          if (b_mag == '0) state_d = S_FIX;
`endif
        end
      end
      S_BUSY: begin
        hi_d     = {it_cout, it_sum[XLEN-1:1]};
        lo_d     = {it_sum[0], lo_q[XLEN-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
`ifdef YSYX_25040111_MUL_EARLY_OUT_EN
        if (mplier_q[XLEN-1:1] == '0) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        res_d       = (op_q == MUL_OP_MUL) ? fix_prod[XLEN-1:0] : fix_prod[2*XLEN-1:XLEN];
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  // State register; reset clears control and datapath alike
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= MUL_OP_MUL;
      neg_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;

endmodule

// File: tb/tb_ysyx_25040111_mul_seq.sv
// Directed bench for the iterative multiplier: vector table plus back-pressure,
// flush and mid-operation reset sequences.
module tb_ysyx_25040111_mul_seq;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;

  ysyx_25040111_mul_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check_lat(input string name, input int lat);
    n_chk++;
`ifdef YSYX_25040111_MUL_EARLY_OUT_EN
    if (lat >= 2 && lat <= 34) n_pass++;
    else $display("FAIL %s: latency %0d, expected 2..34", name, lat);
`else
    if (lat == 34) n_pass++;
    else $display("FAIL %s: latency %0d, expected 34", name, lat);
`endif
  endtask

  // Wait after an accept edge for out_valid; lat counts the accept cycle as 0.
  task automatic wait_result(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (out_valid) begin
        lat = i + 1;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit ok);
    @(negedge clock);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_result(lat, ok);
    res = out_result;
    if (ok) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int          lat;
    bit          ok;
    bit          seen;

    vecs[0]  = '{OP_MULHU,  32'h0000_0003, 32'h0000_0005, 32'h0000_0000};
    vecs[1]  = '{OP_MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[6]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[7]  = '{OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[8]  = '{OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[9]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[10] = '{OP_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[11] = '{OP_MUL,    32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[12] = '{OP_MULH,   32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[13] = '{OP_MULH,   32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[14] = '{OP_MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[15] = '{OP_MULHU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001};
    vecs[16] = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[17] = '{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check32("rst_in_ready",   {31'b0, in_ready},  32'd1);
    check32("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    check32("rst_out_result", out_result,         32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, ok);
      check32($sformatf("v%0d_done", i), {31'b0, ok}, 32'd1);
      if (ok) begin
        check32($sformatf("v%0d_result", i), res, vecs[i].exp);
        check_lat($sformatf("v%0d_latency", i), lat);
      end
    end

    // Back-pressure in DONE, then accept the next op one cycle after handshake
    @(negedge clock);
    in_op = OP_MUL; in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_result(lat, ok);
    check32("bp_done", {31'b0, ok}, 32'd1);
    held = out_result;
    check32("bp_first_result", held, 32'h0000_000F);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check32($sformatf("bp_valid_%0d", k),  {31'b0, out_valid}, 32'd1);
      check32($sformatf("bp_stable_%0d", k), out_result,         held);
      check32($sformatf("bp_ready_%0d", k),  {31'b0, in_ready},  32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    in_op = OP_MULHU; in_a = 32'h1234_5678; in_b = 32'h0000_0010; in_valid = 1'b1;
    @(posedge clock); #1;
    check32("hs_valid_drop", {31'b0, out_valid}, 32'd0);
    check32("hs_ready_back", {31'b0, in_ready},  32'd1);
    @(posedge clock); #1;
    check32("next_accepted", {31'b0, in_ready},  32'd0);
    in_valid = 1'b0;
    wait_result(lat, ok);
    check32("next_done", {31'b0, ok}, 32'd1);
    check32("next_result", out_result, 32'h0000_0001);
    check_lat("next_latency", lat);
    @(posedge clock); #1;

    // Flush at BUSY iteration 10 with in_valid raised in the same cycle
    @(negedge clock);
    in_op = OP_MUL; in_a = 32'h1234_5678; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    in_op = OP_MUL; in_a = 32'd5; in_b = 32'd5; in_valid = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check32("flush_idle_ready", {31'b0, in_ready},  32'd1);
    check32("flush_no_valid",   {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check32("flush_no_result", {31'b0, seen}, 32'd0);
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, ok);
    check32("post_flush_done", {31'b0, ok}, 32'd1);
    check32("post_flush_result", res, 32'hFFFF_FFEB);

    // Reset in the middle of an operation clears the held result
    @(negedge clock);
    in_op = OP_MULHU; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check32("mid_rst_ready",  {31'b0, in_ready},  32'd1);
    check32("mid_rst_valid",  {31'b0, out_valid}, 32'd0);
    check32("mid_rst_result", out_result,         32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ok);
    check32("post_rst_done", {31'b0, ok}, 32'd1);
    check32("post_rst_result", res, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
